// File: rtl/pipe_pkg.sv
// Shared pipeline-control types and constants for the hazard unit.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } hazState_t;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int ZERO_REG       = 0;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (enable && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use / branch-flush / memory-hold steering for the 5-stage pipeline.
// Define HAZARD_PERF_EN to build the stall/flush/hold performance counters.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0] IDEX_Rt,
  input  logic [REG_ADDR_W-1:0] IFID_Rs,
  input  logic [REG_ADDR_W-1:0] IFID_Rt,
  input  logic                  IFID_UsesRt,
  input  logic                  BranchTaken,
  input  logic                  mem_busy,
  output logic                  hazardMux,
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic                  IFID_Flush,
  output logic                  IDEX_Flush,
  output logic                  EXMEM_Flush,
  output logic                  pipeHold,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count,
  output logic [CNT_W-1:0]      hold_count
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : gBadFlushCycles
    $error("hazard_unit: FLUSH_CYCLES must be within 1..3");
  end

  hazState_t  state, nextState;
  logic [1:0] fcnt, nextFcnt;
  logic       loadUse;

  assign loadUse = IDEX_MemRead && (IDEX_Rt != REG_ADDR_W'(ZERO_REG)) &&
                   ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  always_comb begin
    hazardMux   = 1'b0;
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    pipeHold    = 1'b0;
    nextState   = state;
    nextFcnt    = fcnt;

    if (state == FLUSH && !mem_busy) begin
      // Branch shadow: later branches and load-uses are already squashed.
      hazardMux  = 1'b1;
      IFID_Flush = 1'b1;
      if (fcnt == 2'd0)
        nextState = RUN;
      else
        nextFcnt = fcnt - 2'd1;
    end else if (mem_busy) begin
      // Freeze everything; a pending flush window resumes where it stopped.
      pipeHold  = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      nextState = (state == FLUSH) ? FLUSH : MEM_WAIT;
    end else if (BranchTaken) begin
      hazardMux   = 1'b1;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        nextState = FLUSH;
        nextFcnt  = 2'(FLUSH_CYCLES - 2);
      end else begin
        nextState = RUN;
      end
    end else if (loadUse && state != LOAD_STALL) begin
      hazardMux = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      nextState = LOAD_STALL;
    end else begin
      nextState = RUN;
    end

    if (reset) begin
      hazardMux   = 1'b1;
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
      pipeHold    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      fcnt  <= 2'd0;
    end else begin
      state <= nextState;
      fcnt  <= nextFcnt;
    end
  end

`ifdef HAZARD_PERF_EN
  logic stallEvt;

  // Only a load-use stall both bubbles ID/EX and blocks the PC.
  assign stallEvt = hazardMux & ~PCWrite & ~pipeHold;

  sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clock (clock), .reset (reset), .enable (stallEvt),   .count (stall_count)
  );
  sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clock (clock), .reset (reset), .enable (IFID_Flush), .count (flush_count)
  );
  sat_counter #(.CNT_W(CNT_W)) uHoldCnt (
    .clock (clock), .reset (reset), .enable (pipeHold),   .count (hold_count)
  );
`else
  assign stall_count = '0;
  assign flush_count = '0;
  assign hold_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed sequences then random traffic vs a window-based model.
module tb_hazard_unit;

  localparam int AW = 5;
  localparam int FC = 3;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          IDEX_MemRead = 1'b0;
  logic [AW-1:0] IDEX_Rt = '0;
  logic [AW-1:0] IFID_Rs = '0;
  logic [AW-1:0] IFID_Rt = '0;
  logic          IFID_UsesRt = 1'b0;
  logic          BranchTaken = 1'b0;
  logic          mem_busy = 1'b0;
  logic          hazardMux, PCWrite, IFIDWrite, IFID_Flush, IDEX_Flush, EXMEM_Flush, pipeHold;
  logic [CW-1:0] stall_count, flush_count, hold_count;

  hazard_unit #(.REG_ADDR_W(AW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .BranchTaken(BranchTaken), .mem_busy(mem_busy), .hazardMux(hazardMux),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush), .pipeHold(pipeHold),
    .stall_count(stall_count), .flush_count(flush_count), .hold_count(hold_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          hMux, pcW, ifidW, fIfid, fIdex, fExmem, hold;
    logic [CW-1:0] sCnt, fCnt, hCnt;
  } expect_t;

  expect_t expQ[$];
  int checks = 0;
  int failures = 0;

  // Model state: owed shadow-flush cycles, whether the previous cycle was a stall, event tallies.
  int shadowLeft = 0;
  bit prevStall = 0;
  int nStall = 0, nFlush = 0, nHold = 0;

  function automatic int sat(input int v);
    return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
  endfunction

  task automatic cycle(input bit rst, input bit mr, input int xRt, input int rs, input int rt,
                       input bit uses, input bit br, input bit busy);
    expect_t e;
    bit match;
    @(posedge clock);
    #1;
    reset = rst; IDEX_MemRead = mr; IDEX_Rt = AW'(xRt); IFID_Rs = AW'(rs);
    IFID_Rt = AW'(rt); IFID_UsesRt = uses; BranchTaken = br; mem_busy = busy;

    match = mr && (xRt != 0) && ((xRt == rs) || (uses && xRt == rt));
`ifdef HAZARD_PERF_EN
    e.sCnt = CW'(sat(nStall)); e.fCnt = CW'(sat(nFlush)); e.hCnt = CW'(sat(nHold));
`else
    e.sCnt = '0; e.fCnt = '0; e.hCnt = '0;
`endif
    if (rst) begin
      e.hMux = 1; e.pcW = 0; e.ifidW = 0; e.fIfid = 1; e.fIdex = 1; e.fExmem = 1; e.hold = 0;
      e.sCnt = '0; e.fCnt = '0; e.hCnt = '0;
      shadowLeft = 0; prevStall = 0; nStall = 0; nFlush = 0; nHold = 0;
    end else if (busy) begin
      e.hMux = 0; e.pcW = 0; e.ifidW = 0; e.fIfid = 0; e.fIdex = 0; e.fExmem = 0; e.hold = 1;
      nHold++; prevStall = 0;
    end else if (shadowLeft > 0) begin
      e.hMux = 1; e.pcW = 1; e.ifidW = 1; e.fIfid = 1; e.fIdex = 0; e.fExmem = 0; e.hold = 0;
      shadowLeft--; nFlush++; prevStall = 0;
    end else if (br) begin
      e.hMux = 1; e.pcW = 1; e.ifidW = 1; e.fIfid = 1; e.fIdex = 1; e.fExmem = 1; e.hold = 0;
      shadowLeft = FC - 1; nFlush++; prevStall = 0;
    end else if (match && !prevStall) begin
      e.hMux = 1; e.pcW = 0; e.ifidW = 0; e.fIfid = 0; e.fIdex = 0; e.fExmem = 0; e.hold = 0;
      nStall++; prevStall = 1;
    end else begin
      e.hMux = 0; e.pcW = 1; e.ifidW = 1; e.fIfid = 0; e.fIdex = 0; e.fExmem = 0; e.hold = 0;
      prevStall = 0;
    end
    expQ.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle once stimulus for it has been issued.
  initial begin
    expect_t e;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("hazardMux",   int'(hazardMux),   int'(e.hMux));
        chk("PCWrite",     int'(PCWrite),     int'(e.pcW));
        chk("IFIDWrite",   int'(IFIDWrite),   int'(e.ifidW));
        chk("IFID_Flush",  int'(IFID_Flush),  int'(e.fIfid));
        chk("IDEX_Flush",  int'(IDEX_Flush),  int'(e.fIdex));
        chk("EXMEM_Flush", int'(EXMEM_Flush), int'(e.fExmem));
        chk("pipeHold",    int'(pipeHold),    int'(e.hold));
        chk("stall_count", int'(stall_count), int'(e.sCnt));
        chk("flush_count", int'(flush_count), int'(e.fCnt));
        chk("hold_count",  int'(hold_count),  int'(e.hCnt));
      end
    end
  end

  initial begin
    int budget;
    // reset
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // load-use on $2, held for a second cycle to exercise masking
    cycle(0, 1, 2, 2, 5, 1, 0, 0);
    cycle(0, 1, 2, 2, 5, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // $zero destination and Rt match without UsesRt
    cycle(0, 1, 0, 0, 0, 1, 0, 0);
    cycle(0, 1, 3, 1, 3, 0, 0, 0);
    cycle(0, 1, 3, 1, 3, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // taken branch pulse
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // memory busy for 4 cycles with a branch pending
    repeat (4) cycle(0, 0, 0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // branch and load-use together
    cycle(0, 1, 4, 4, 0, 1, 1, 0);
    repeat (3) cycle(0, 1, 4, 4, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // reset in the middle of a flush window
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 79) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end
    budget = 20;
    while (expQ.size() > 0 && budget > 0) begin
      @(posedge clock);
      budget--;
    end
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
